// File: rtl/pc_stat_unit.sv
// Architectural PC register, AOK/HLT/ADR/INS status FSM and run counters.
// Optional PC_TRACE_EN builds a circular trace of committed PCs.
module pc_stat_unit #(
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32),
    parameter int CNT_W = 32,
    parameter int TRACE_DEPTH = 8,
    localparam int IDX_W = $clog2(TRACE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ret_valid,
    input  logic              stall,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              instr_valid,
    input  logic              imem_error,
    input  logic              dmem_error,
    input  logic              hlt,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        stat,
    output logic              running,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt,
    input  logic [IDX_W-1:0]  trace_rd_idx,
    output logic [ADDR_W-1:0] trace_rd_data,
    output logic              trace_rd_valid
);

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    logic   commit;

    assign commit = (state == S_AOK) && !stall && ret_valid;
    assign stat   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_AOK;
            pc        <= RESET_PC;
            running   <= 1'b1;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state == S_AOK) begin
            if (cycle_cnt != CNT_MAX)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (commit) begin
                if (instr_cnt != CNT_MAX)
                    instr_cnt <= instr_cnt + 1'b1;
                // Fault/halt leave pc pointing at the offending instruction
                priority case (1'b1)
                    imem_error | dmem_error: begin
                        state   <= S_ADR;
                        running <= 1'b0;
                    end
                    !instr_valid: begin
                        state   <= S_INS;
                        running <= 1'b0;
                    end
                    hlt: begin
                        state   <= S_HLT;
                        running <= 1'b0;
                    end
                    default: pc <= next_pc;
                endcase
            end
        end
    end

`ifdef PC_TRACE_EN
    logic [ADDR_W-1:0] trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W:0]    trace_count;
    logic [IDX_W-1:0]  rd_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            trace_count <= '0;
        end else if (commit) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trace_count != (IDX_W+1)'(TRACE_DEPTH))
                trace_count <= trace_count + 1'b1;
        end
    end

    // Storage needs no reset: entries beyond trace_count are masked on read
    always_ff @(posedge clk) begin
        if (commit)
            trace_mem[wr_ptr] <= pc;
    end

    assign rd_slot        = wr_ptr - IDX_W'(1) - trace_rd_idx;
    assign trace_rd_valid = {1'b0, trace_rd_idx} < trace_count;
    assign trace_rd_data  = trace_rd_valid ? trace_mem[rd_slot] : '0;
`else
    logic unused_trace_idx;

    assign unused_trace_idx = ^trace_rd_idx;
    assign trace_rd_data    = '0;
    assign trace_rd_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stat_unit.sv
// Self-checking bench for pc_stat_unit: vector table, corner sequences,
// and random stimulus against a queue-based reference model.
module tb_pc_stat_unit;

    localparam int SAT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ret_valid = 1'b0;
    logic        stall = 1'b0;
    logic [63:0] next_pc = '0;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        dmem_error = 1'b0;
    logic        hlt = 1'b0;
    logic [2:0]  idx_a = '0;
    logic [1:0]  idx_b = '0;

    logic [63:0]      pc_a, td_a, pc_b, td_b;
    logic [2:0]       stat_a, stat_b;
    logic             run_a, run_b, tv_a, tv_b;
    logic [31:0]      cc_a, ic_a;
    logic [SAT_W-1:0] cc_b, ic_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pc_stat_unit u_dut (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .stall(stall),
        .next_pc(next_pc), .instr_valid(instr_valid),
        .imem_error(imem_error), .dmem_error(dmem_error), .hlt(hlt),
        .pc(pc_a), .stat(stat_a), .running(run_a),
        .cycle_cnt(cc_a), .instr_cnt(ic_a),
        .trace_rd_idx(idx_a), .trace_rd_data(td_a), .trace_rd_valid(tv_a)
    );

    pc_stat_unit #(.CNT_W(SAT_W), .TRACE_DEPTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .ret_valid(ret_valid), .stall(stall),
        .next_pc(next_pc), .instr_valid(instr_valid),
        .imem_error(imem_error), .dmem_error(dmem_error), .hlt(hlt),
        .pc(pc_b), .stat(stat_b), .running(run_b),
        .cycle_cnt(cc_b), .instr_cnt(ic_b),
        .trace_rd_idx(idx_b), .trace_rd_data(td_b), .trace_rd_valid(tv_b)
    );

    // Reference model: architectural state as plain numbers, trace as a
    // newest-first list of committed PCs.
    int          m_stat;
    logic [63:0] m_pc;
    longint      m_cyc, m_ins;
    logic [63:0] m_trace[$];

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [64:0] exp_tr(input int idx, input int depth);
`ifdef PC_TRACE_EN
        if (idx < m_trace.size() && idx < depth)
            return {1'b1, m_trace[idx]};
`endif
        return '0;
    endfunction

    task automatic model_reset();
        m_stat = 1;
        m_pc   = 64'd32;
        m_cyc  = 0;
        m_ins  = 0;
        m_trace.delete();
    endtask

    task automatic model_edge();
        if (m_stat != 1) return;
        m_cyc++;
        if (stall || !ret_valid) return;
        m_ins++;
        m_trace.push_front(m_pc);
        if (m_trace.size() > 8) void'(m_trace.pop_back());
        if (imem_error || dmem_error) m_stat = 3;
        else if (!instr_valid)        m_stat = 4;
        else if (hlt)                 m_stat = 2;
        else                          m_pc = next_pc;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [64:0] ta, tb;
        longint mx_b;
        mx_b = (64'd1 << SAT_W) - 1;
        ta = exp_tr(int'(idx_a), 8);
        tb = exp_tr(int'(idx_b), 4);
        chk({tag, " pc"}, pc_a, m_pc);
        chk({tag, " stat"}, 64'(stat_a), 64'(m_stat));
        chk({tag, " running"}, 64'(run_a), 64'(m_stat == 1));
        chk({tag, " cycle_cnt"}, 64'(cc_a), 64'(sat(m_cyc, 64'hFFFFFFFF)));
        chk({tag, " instr_cnt"}, 64'(ic_a), 64'(sat(m_ins, 64'hFFFFFFFF)));
        chk({tag, " trace_valid"}, 64'(tv_a), 64'(ta[64]));
        chk({tag, " trace_data"}, td_a, ta[63:0]);
        chk({tag, " sat pc"}, pc_b, m_pc);
        chk({tag, " sat stat"}, 64'(stat_b), 64'(m_stat));
        chk({tag, " sat cycle_cnt"}, 64'(cc_b), 64'(sat(m_cyc, mx_b)));
        chk({tag, " sat instr_cnt"}, 64'(ic_b), 64'(sat(m_ins, mx_b)));
        chk({tag, " sat trace_valid"}, 64'(tv_b), 64'(tb[64]));
        chk({tag, " sat trace_data"}, td_b, tb[63:0]);
    endtask

    task automatic set_idle();
        ret_valid   = 1'b0;
        stall       = 1'b0;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        dmem_error  = 1'b0;
        hlt         = 1'b0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
    endtask

    task automatic commit_to(input logic [63:0] npc, input string tag);
        ret_valid = 1'b1;
        next_pc   = npc;
        step(tag);
        ret_valid = 1'b0;
    endtask

    typedef struct {
        logic        rv, st;
        logic [63:0] npc;
        logic        iv, ie, de, h;
        logic [63:0] e_pc;
        logic [2:0]  e_stat;
        logic [31:0] e_ic, e_cc;
    } vec_t;

    vec_t vec[11];

    initial begin
        vec[0]  = '{1'b1, 1'b0, 64'd42, 1'b1, 1'b0, 1'b0, 1'b0, 64'd42, 3'd1, 32'd1, 32'd1};
        vec[1]  = '{1'b1, 1'b0, 64'd52, 1'b1, 1'b0, 1'b0, 1'b0, 64'd52, 3'd1, 32'd2, 32'd2};
        vec[2]  = '{1'b1, 1'b0, 64'd54, 1'b1, 1'b0, 1'b0, 1'b0, 64'd54, 3'd1, 32'd3, 32'd3};
        vec[3]  = '{1'b1, 1'b1, 64'd99, 1'b1, 1'b0, 1'b0, 1'b0, 64'd54, 3'd1, 32'd3, 32'd4};
        vec[4]  = '{1'b1, 1'b1, 64'd99, 1'b0, 1'b1, 1'b0, 1'b1, 64'd54, 3'd1, 32'd3, 32'd5};
        vec[5]  = '{1'b1, 1'b1, 64'd99, 1'b1, 1'b0, 1'b1, 1'b0, 64'd54, 3'd1, 32'd3, 32'd6};
        vec[6]  = '{1'b1, 1'b1, 64'd99, 1'b1, 1'b0, 1'b0, 1'b1, 64'd54, 3'd1, 32'd3, 32'd7};
        vec[7]  = '{1'b0, 1'b0, 64'd77, 1'b0, 1'b0, 1'b0, 1'b0, 64'd54, 3'd1, 32'd3, 32'd8};
        vec[8]  = '{1'b1, 1'b0, 64'd99, 1'b1, 1'b0, 1'b0, 1'b1, 64'd54, 3'd2, 32'd4, 32'd9};
        vec[9]  = '{1'b1, 1'b0, 64'd10, 1'b1, 1'b1, 1'b0, 1'b0, 64'd54, 3'd2, 32'd4, 32'd9};
        vec[10] = '{1'b1, 1'b0, 64'd20, 1'b0, 1'b0, 1'b1, 1'b0, 64'd54, 3'd2, 32'd4, 32'd9};

        model_reset();
        #12;
        rst_n = 1'b1;
        set_idle();

        // Async reset in the middle of a cycle, from a non-reset state
        commit_to(64'd500, "pre");
        commit_to(64'd600, "pre");
        @(posedge clk);
        model_edge();
        #3;
        chk("pre-reset pc", pc_a, 64'd600);
        do_reset("async reset");

        for (int i = 0; i < 11; i++) begin
            ret_valid   = vec[i].rv;
            stall       = vec[i].st;
            next_pc     = vec[i].npc;
            instr_valid = vec[i].iv;
            imem_error  = vec[i].ie;
            dmem_error  = vec[i].de;
            hlt         = vec[i].h;
            step("vec");
            chk($sformatf("vec%0d pc", i), pc_a, vec[i].e_pc);
            chk($sformatf("vec%0d stat", i), 64'(stat_a), 64'(vec[i].e_stat));
            chk($sformatf("vec%0d instr_cnt", i), 64'(ic_a), 64'(vec[i].e_ic));
            chk($sformatf("vec%0d cycle_cnt", i), 64'(cc_a), 64'(vec[i].e_cc));
            chk($sformatf("vec%0d running", i), 64'(run_a),
                64'(vec[i].e_stat == 3'd1));
        end
        set_idle();

        do_reset("reset adr");
        ret_valid   = 1'b1;
        imem_error  = 1'b1;
        instr_valid = 1'b0;
        hlt         = 1'b1;
        next_pc     = 64'd7;
        step("adr");
        chk("adr priority stat", 64'(stat_a), 64'd3);
        chk("adr pc held", pc_a, 64'd32);
        chk("adr instr_cnt", 64'(ic_a), 64'd1);

        do_reset("reset ins");
        ret_valid   = 1'b1;
        instr_valid = 1'b0;
        step("ins");
        chk("ins stat", 64'(stat_a), 64'd4);

        do_reset("reset dmem");
        ret_valid  = 1'b1;
        dmem_error = 1'b1;
        step("dmem");
        chk("dmem stat", 64'(stat_a), 64'd3);

        do_reset("reset sat");
        for (int i = 0; i < 20; i++) step("idle");
        chk("sat cycle_cnt", 64'(cc_b), 64'd15);
        chk("wide cycle_cnt", 64'(cc_a), 64'd20);
        for (int i = 0; i < 18; i++) commit_to(64'(100 + i), "sat commit");
        chk("sat instr_cnt", 64'(ic_b), 64'd15);

        do_reset("reset trace");
        for (int i = 0; i < 6; i++) commit_to(64'(42 + 10 * i), "trace commit");
        for (int i = 0; i < 4; i++) begin
            idx_b = 2'(i);
            idx_a = 3'(i + 4);
            #1;
`ifdef PC_TRACE_EN
            chk($sformatf("trace4 idx%0d valid", i), 64'(tv_b), 64'd1);
            chk($sformatf("trace4 idx%0d data", i), td_b, 64'(82 - 10 * i));
            chk($sformatf("trace8 idx%0d valid", i + 4), 64'(tv_a),
                64'(i < 2));
            chk($sformatf("trace8 idx%0d data", i + 4), td_a,
                (i < 2) ? 64'(42 - 10 * i) : 64'd0);
`else
            chk($sformatf("trace off idx%0d valid", i), 64'(tv_b), 64'd0);
            chk($sformatf("trace off idx%0d data", i), td_b, 64'd0);
`endif
            check_all("trace read");
        end

        do_reset("reset random");
        for (int n = 0; n < 800; n++) begin
            if (n % 60 == 59) do_reset("reset random");
            ret_valid   = ($urandom % 4) != 0;
            stall       = ($urandom % 4) == 0;
            next_pc     = {$urandom, $urandom};
            instr_valid = ($urandom % 48) != 0;
            imem_error  = ($urandom % 64) == 0;
            dmem_error  = ($urandom % 64) == 0;
            hlt         = ($urandom % 48) == 0;
            idx_a       = 3'($urandom);
            idx_b       = 2'($urandom);
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
